// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: start detect, mid-bit sampling, parity-checker drive, byte assembly.
// Optional build macro RX_MAJORITY_EN: each bit is a 3-sample majority vote around mid-bit.
module uart_rx_ctrl #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 baud_tick,
  input  logic                 rx,
  input  logic                 use_parity,
  input  logic                 parity_type,
  output logic                 par_clr,
  output logic                 par_serial,
  output logic                 par_done,
  output logic                 par_use,
  output logic                 par_type,
  input  logic                 par_check,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy
);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

`ifdef RX_MAJORITY_EN
  // Decision lands one tick after mid-bit, so the data counter starts one tick ahead.
  localparam logic [TW-1:0] START_DEC  = TW'(OVERSAMPLE/2);
  localparam logic [TW-1:0] BIT_DEC    = '0;
  localparam logic [TW-1:0] DATA_START = TW'(1);
`else
  localparam logic [TW-1:0] START_DEC  = TW'(OVERSAMPLE/2 - 1);
  localparam logic [TW-1:0] BIT_DEC    = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] DATA_START = '0;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_DONE, S_BREAK
  } state_t;

  state_t                 r_state,      w_state_nxt;
  logic [TW-1:0]          r_tick_cnt,   w_tick_nxt, w_tick_inc;
  logic [BW-1:0]          r_bit_cnt,    w_bit_nxt;
  logic [DATA_BITS-1:0]   r_shift,      w_shift_nxt;
  logic [DATA_BITS-1:0]   r_rx_data,    w_data_nxt;
  logic                   r_stop_bit,   w_stop_nxt;
  logic                   r_done_pend,  w_pend_nxt;
  logic                   r_par_serial, w_ser_nxt;
  logic                   r_par_done,   w_done_nxt;
  logic                   r_par_use,    w_use_nxt;
  logic                   r_par_type,   w_type_nxt;
  logic                   r_rx_valid,   w_valid_nxt;
  logic                   r_parity_err, w_perr_nxt;
  logic                   r_frame_err,  w_ferr_nxt;
  logic                   r_par_clr,    r_busy;
  logic                   w_bit;

`ifdef RX_MAJORITY_EN
  logic [1:0] r_smp;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         r_smp <= 2'b11;
    else if (baud_tick) r_smp <= {r_smp[0], rx};
  end

  assign w_bit = maj3(r_smp[1], r_smp[0], rx);
`else
  assign w_bit = rx;
`endif

  assign w_tick_inc = (r_tick_cnt == TW'(OVERSAMPLE - 1)) ? '0 : r_tick_cnt + TW'(1);

  always_comb begin
    w_state_nxt = r_state;
    w_tick_nxt  = r_tick_cnt;
    w_bit_nxt   = r_bit_cnt;
    w_shift_nxt = r_shift;
    w_data_nxt  = r_rx_data;
    w_stop_nxt  = r_stop_bit;
    w_pend_nxt  = 1'b0;
    w_ser_nxt   = 1'b0;
    w_done_nxt  = r_done_pend;
    w_use_nxt   = r_par_use;
    w_type_nxt  = r_par_type;
    w_valid_nxt = 1'b0;
    w_perr_nxt  = r_parity_err;
    w_ferr_nxt  = r_frame_err;
    case (r_state)
      S_IDLE: begin
        w_tick_nxt = '0;
        if (!rx) begin
          w_state_nxt = S_START;
          w_use_nxt   = use_parity;
          w_type_nxt  = parity_type;
        end
      end
      S_START: if (baud_tick) begin
        if (r_tick_cnt == START_DEC) begin
          if (w_bit) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_DATA;
            w_tick_nxt  = DATA_START;
            w_bit_nxt   = '0;
          end
        end else begin
          w_tick_nxt = r_tick_cnt + TW'(1);
        end
      end
      S_DATA: if (baud_tick) begin
        w_tick_nxt = w_tick_inc;
        if (r_tick_cnt == BIT_DEC) begin
          w_shift_nxt = {w_bit, r_shift[DATA_BITS-1:1]};
          w_ser_nxt   = w_bit;
          w_bit_nxt   = r_bit_cnt + BW'(1);
          if (r_bit_cnt == BW'(DATA_BITS - 1))
            w_state_nxt = r_par_use ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: if (baud_tick) begin
        w_tick_nxt = w_tick_inc;
        if (r_tick_cnt == BIT_DEC) begin
          w_ser_nxt   = w_bit;
          w_pend_nxt  = 1'b1;
          w_state_nxt = S_STOP;
        end
      end
      S_STOP: if (baud_tick) begin
        w_tick_nxt = w_tick_inc;
        if (r_tick_cnt == BIT_DEC) begin
          w_stop_nxt  = w_bit;
          w_state_nxt = S_DONE;
        end
      end
      // One cycle after the stop sample so the checker result has settled.
      S_DONE: begin
        w_valid_nxt = 1'b1;
        w_data_nxt  = r_shift;
        w_ferr_nxt  = ~r_stop_bit;
        w_perr_nxt  = r_par_use & ~par_check;
        w_state_nxt = r_stop_bit ? S_IDLE : S_BREAK;
      end
      S_BREAK: if (rx) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_tick_cnt   <= '0;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_rx_data    <= '0;
      r_stop_bit   <= 1'b0;
      r_done_pend  <= 1'b0;
      r_par_serial <= 1'b0;
      r_par_done   <= 1'b0;
      r_par_use    <= 1'b0;
      r_par_type   <= 1'b0;
      r_rx_valid   <= 1'b0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
      r_par_clr    <= 1'b1;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_tick_cnt   <= w_tick_nxt;
      r_bit_cnt    <= w_bit_nxt;
      r_shift      <= w_shift_nxt;
      r_rx_data    <= w_data_nxt;
      r_stop_bit   <= w_stop_nxt;
      r_done_pend  <= w_pend_nxt;
      r_par_serial <= w_ser_nxt;
      r_par_done   <= w_done_nxt;
      r_par_use    <= w_use_nxt;
      r_par_type   <= w_type_nxt;
      r_rx_valid   <= w_valid_nxt;
      r_parity_err <= w_perr_nxt;
      r_frame_err  <= w_ferr_nxt;
      r_par_clr    <= (w_state_nxt == S_IDLE) || (w_state_nxt == S_BREAK);
      r_busy       <= (w_state_nxt != S_IDLE);
    end
  end

  assign par_clr    = r_par_clr;
  assign par_serial = r_par_serial;
  assign par_done   = r_par_done;
  assign par_use    = r_par_use;
  assign par_type   = r_par_type;
  assign rx_data    = r_rx_data;
  assign rx_valid   = r_rx_valid;
  assign parity_err = r_parity_err;
  assign frame_err  = r_frame_err;
  assign busy       = r_busy;
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: serial frame driver, parity-checker model and frame-level reference.
module tb_uart_rx_ctrl;
  localparam int DB       = 8;
  localparam int OS       = 16;
  localparam int TICK_DIV = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          baud_tick = 1'b0;
  logic          rx = 1'b1;
  logic          use_parity = 1'b0;
  logic          parity_type = 1'b0;
  logic          par_clr, par_serial, par_done, par_use, par_type, par_check;
  logic [DB-1:0] rx_data;
  logic          rx_valid, parity_err, frame_err, busy;

  int            n_vec = 0;
  int            n_err = 0;
  int            div = 0;
  logic          chk_st = 1'b0;
  int            vcnt = 0, ser_cnt = 0, done_cnt = 0, ovl_cnt = 0;
  logic [DB-1:0] last_data = '0;
  logic          last_perr = 1'b0, last_ferr = 1'b0;

  uart_rx_ctrl #(.DATA_BITS(DB), .OVERSAMPLE(OS)) dut (
    .clk(clk), .reset(reset), .baud_tick(baud_tick), .rx(rx),
    .use_parity(use_parity), .parity_type(parity_type),
    .par_clr(par_clr), .par_serial(par_serial), .par_done(par_done),
    .par_use(par_use), .par_type(par_type), .par_check(par_check),
    .rx_data(rx_data), .rx_valid(rx_valid), .parity_err(parity_err),
    .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (div == TICK_DIV - 1) begin
      div       <= 0;
      baud_tick <= 1'b1;
    end else begin
      div       <= div + 1;
      baud_tick <= 1'b0;
    end
  end

  // External parity checker: cleared by par_clr, toggles per one bit, extra toggle on done for odd.
  always @(posedge clk) begin
    if (par_clr) chk_st <= 1'b0;
    else         chk_st <= chk_st ^ par_serial ^ (par_done & par_type);
  end
  assign par_check = ~chk_st;

  always @(negedge clk) begin
    if (rx_valid) begin
      vcnt      <= vcnt + 1;
      last_data <= rx_data;
      last_perr <= parity_err;
      last_ferr <= frame_err;
    end
    if (par_serial)             ser_cnt  <= ser_cnt + 1;
    if (par_done)               done_cnt <= done_cnt + 1;
    if (par_serial && par_done) ovl_cnt  <= ovl_cnt + 1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk_eq(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_tick();
    do @(negedge clk); while (baud_tick !== 1'b1);
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic v);
    rx = v;
    repeat (OS) wait_tick();
  endtask

  task automatic send_frame(input logic [DB-1:0] d, input logic up, input logic pt,
                            input logic pb, input logic sb, input int nstop, input logic tog);
    use_parity  = up;
    parity_type = pt;
    send_bit(1'b0);
    if (tog) begin
      use_parity  = ~up;
      parity_type = ~pt;
    end
    for (int i = 0; i < DB; i++) send_bit(d[i]);
    if (tog) chk_eq("par_use_hold", int'(par_use), int'(up));
    if (up) send_bit(pb);
    for (int i = 0; i < nstop; i++) send_bit(sb);
    if (!sb) chk_eq("break_busy", int'(busy), 1);
    rx = 1'b1;
    repeat (2 * OS) wait_tick();
  endtask

  task automatic do_frame(input string tag, input logic [DB-1:0] d, input logic up, input logic pt,
                          input logic pb, input logic sb, input int nstop, input logic tog);
    int v0, s0, d0, ones, exp_perr;
    v0 = vcnt; s0 = ser_cnt; d0 = done_cnt;
    ones = $countones(d);
    exp_perr = (up && (((ones + int'(pb)) % 2) != int'(pt))) ? 1 : 0;
    send_frame(d, up, pt, pb, sb, nstop, tog);
    chk_eq({tag, "_nvalid"}, vcnt - v0, 1);
    chk_eq({tag, "_data"},   int'(last_data), int'(d));
    chk_eq({tag, "_perr"},   int'(last_perr), exp_perr);
    chk_eq({tag, "_ferr"},   int'(last_ferr), sb ? 0 : 1);
    chk_eq({tag, "_nser"},   ser_cnt - s0, ones + int'(up & pb));
    chk_eq({tag, "_ndone"},  done_cnt - d0, int'(up));
    chk_eq({tag, "_hold"},   int'(rx_data), int'(d));
    chk_eq({tag, "_idle"},   int'(busy), 0);
  endtask

  initial begin
    int v0;
    logic [DB-1:0] d;
    logic up, pt, pb, sb, tog;
    int nstop;

    #2 reset = 1'b0;
    repeat (3) @(negedge clk);
    chk_eq("rst_par_clr", int'(par_clr), 1);
    chk_eq("rst_busy",    int'(busy), 0);
    chk_eq("rst_valid",   int'(rx_valid), 0);
    chk_eq("rst_data",    int'(rx_data), 0);
    chk_eq("rst_strobes", int'({par_serial, par_done, par_use, par_type, parity_err, frame_err}), 0);
    reset = 1'b1;
    repeat (2 * OS) wait_tick();

    do_frame("t55",   8'h55, 1'b1, 1'b0, 1'b0, 1'b1, 1, 1'b0);
    do_frame("tA3bad",8'hA3, 1'b1, 1'b1, 1'b0, 1'b1, 1, 1'b0);
    do_frame("tA3ok", 8'hA3, 1'b1, 1'b1, 1'b1, 1'b1, 1, 1'b0);
    do_frame("t3Cbrk",8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 3, 1'b0);

    // False start: 4 ticks low, then high.
    v0 = vcnt;
    wait_tick();
    rx = 1'b0;
    repeat (4) wait_tick();
    chk_eq("fs_busy_hi", int'(busy), 1);
    rx = 1'b1;
    for (int i = 0; i < 5 * TICK_DIV + 4 && busy; i++) @(negedge clk);
    chk_eq("fs_busy_lo", int'(busy), 0);
    repeat (2 * OS) wait_tick();
    chk_eq("fs_nvalid", vcnt - v0, 0);

    // Reset during data bit 3 of an 0xFF frame.
    v0 = vcnt;
    use_parity = 1'b1;
    parity_type = 1'b0;
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    rx = 1'b1;
    repeat (5) wait_tick();
    chk_eq("mid_busy", int'(busy), 1);
    reset = 1'b0;
    @(negedge clk);
    chk_eq("mid_rst_busy", int'(busy), 0);
    chk_eq("mid_rst_clr",  int'(par_clr), 1);
    chk_eq("mid_rst_data", int'(rx_data), 0);
    chk_eq("mid_rst_use",  int'(par_use), 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2 * OS) wait_tick();
    chk_eq("mid_nvalid", vcnt - v0, 0);
    do_frame("tFF", 8'hFF, 1'b1, 1'b0, 1'b0, 1'b1, 1, 1'b0);

    do_frame("tog", 8'h5A, 1'b1, 1'b1, 1'b1, 1'b1, 1, 1'b1);

    for (int n = 0; n < 28; n++) begin
      d   = DB'($urandom);
      up  = 1'($urandom);
      pt  = 1'($urandom);
      pb  = (^d) ^ pt;
      if ($urandom_range(0, 3) == 0) pb = ~pb;
      sb  = ($urandom_range(0, 5) != 0);
      nstop = sb ? 1 : $urandom_range(1, 3);
      tog = ($urandom_range(0, 4) == 0);
      do_frame("rnd", d, up, pt, pb, sb, nstop, tog);
    end

    chk_eq("no_overlap", ovl_cnt, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
UART receive sequencer that sits between the synchronized rx line and the parity checker.
- Finds the start bit and samples data, parity and stop bits at the middle of each bit using a 16x baud tick.
- Feeds each sampled bit to the parity checker as a one-cycle pulse and strobes its done input.
- Assembles the byte and reports it with parity and framing status on a one-cycle valid strobe.

Parameters:
DATA_BITS, 8, number of data bits per frame (5..8), received LSB first
OVERSAMPLE, 16, baud_tick pulses per bit period; mid-bit is tick count OVERSAMPLE/2-1

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
baud_tick  input  1  one-clk pulse at OVERSAMPLE x baud rate
rx  input  1  serial line, idle high, already synchronized to clk
use_parity  input  1  1 = frame carries a parity bit
parity_type  input  1  1 = odd, 0 = even
par_clr  output  1  drives checker reset (sync, active-high)
par_serial  output  1  drives checker serial_in; 1-clk pulse per sampled 1 bit
par_done  output  1  drives checker done; 1-clk pulse
par_use  output  1  latched use_parity to checker
par_type  output  1  latched parity_type to checker
par_check  input  1  checker result, 1 = ok
rx_data  output  DATA_BITS  received word, held until next valid
rx_valid  output  1  1-clk strobe, frame complete
parity_err  output  1  qualified by rx_valid
frame_err  output  1  qualified by rx_valid
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (reset=0, async): state=IDLE, par_clr=1, all other outputs 0, rx_data=0, tick_cnt=0, bit_cnt=0.
- Reset asserted mid-frame: frame is abandoned immediately; no rx_valid is produced.
- All outputs are registered. tick_cnt advances only on baud_tick.
- IDLE: par_clr=1. When rx=0 in any clk cycle:
  - go to START, tick_cnt=0.
  - latch use_parity and parity_type into par_use and par_type.
  - use_parity and parity_type changes after this point are ignored until IDLE.
- START: par_clr=0. On the baud_tick where tick_cnt=7:
  - rx=1: false start, go to IDLE; no outputs change.
  - rx=0: tick_cnt=0, bit_cnt=0, go to DATA.
- DATA: on the baud_tick where tick_cnt=15 (one full bit later, i.e. mid-bit):
  - shift rx into rx_data at the MSB and shift right, so the first bit ends at LSB.
  - par_serial=rx for exactly one clk.
  - bit_cnt++.
  - After DATA_BITS bits: go to PARITY if par_use=1, else STOP.
- PARITY: at mid-bit, par_serial=rx for one clk. On the following clk, par_done=1 for one clk.
  - par_serial and par_done are never high in the same cycle.
- STOP: at mid-bit, sample rx. On the next clk (par_check has settled by then):
  - rx_valid=1.
  - frame_err = ~rx.
  - parity_err = par_use & ~par_check.
  - go to IDLE if rx=1, else to BREAK.
- BREAK: par_clr=1; wait until rx=1, then go to IDLE. No rx_valid is produced while rx is held low.
- rx_valid, par_serial and par_done are single-cycle strobes. parity_err and frame_err hold until the next rx_valid.
- Checker contract: its status is cleared by par_clr. It toggles on par_serial and toggles again on par_done when par_type=1. Result: par_check=1 when data plus parity ones count is even (even parity) or odd (odd parity).
- baud_tick coincident with a state transition is consumed by the state being left.

Optional Feature:
RX_MAJORITY_EN
- Defined: each bit value is the majority of rx sampled on the three baud_ticks centered on mid-bit (tick_cnt 6, 7, 8 for the start bit; 14, 15, 0 for data, parity and stop). The decision is made after the third sample.
  - START false-start check uses the majority value.
  - par_serial and the STOP decision are delayed accordingly.
- Undefined: single sample at mid-bit as above.

Test Plan:
- 0x55, use_parity=1, even, parity bit 0, stop 1 -> rx_valid once, rx_data=0x55, parity_err=0, frame_err=0, 4 par_serial pulses.
- 0xA3, odd, parity bit 0 (wrong) -> rx_data=0xA3, parity_err=1, frame_err=0; then 0xA3 with parity bit 1 -> parity_err=0.
- 0x3C, use_parity=0, stop bit 0 held 3 bit-times -> rx_valid with frame_err=1, parity_err=0, no par_done pulse; busy stays 1 until rx returns to 1.
- rx low for 4 baud_ticks then high -> back to IDLE, no rx_valid, busy drops within 5 ticks.
- reset asserted during DATA bit 3, released, then full 0xFF even-parity frame -> no valid for the aborted frame; next frame rx_data=0xFF, parity_err=0.
- use_parity toggled to 0 mid-frame after start -> frame still decoded with parity bit; par_use unchanged until IDLE.
